// File: rtl/cas_stream.sv
// Cassette tape player: fetches bytes from a buffer and emits them LSB first as an FSK
// waveform (one high/low cycle per bit, half-period chosen by the bit value).
module cas_stream #(
    parameter int ADDR_W = 16,
    parameter int HALF1  = 186,
    parameter int HALF0  = 373
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              en,
    input  logic              rewind,
    input  logic [ADDR_W-1:0] tape_len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    output logic              data,
    output logic              playing,
    output logic              eot
);

    if (HALF1 < 1 || HALF1 > 4095) begin : g_bad_half1
        $error("cas_stream: HALF1 must be in 1..4095");
    end
    if (HALF0 < 1 || HALF0 > 4095) begin : g_bad_half0
        $error("cas_stream: HALF0 must be in 1..4095");
    end

    localparam logic [11:0] H1 = 12'(HALF1);
    localparam logic [11:0] H0 = 12'(HALF0);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HI, S_LO, S_EOT} state_t;

    state_t            state, state_n;
    logic [11:0]       cnt, cnt_n;
    logic [7:0]        sr, sr_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [ADDR_W-1:0] addr_n;
    logic [1:0]        rst_sync;
    logic              rst;
    logic              tick;
    state_t            fetch_st;

    // Assert immediately, release two clk edges later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rst_sync <= 2'b11;
        else       rst_sync <= {rst_sync[0], 1'b0};
    end
    assign rst = rst_sync[1];

    assign tick     = ce & en;
    assign fetch_st = (mem_addr < tape_len) ? S_REQ : S_EOT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sr       <= '0;
            bit_idx  <= '0;
            mem_addr <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sr       <= sr_n;
            bit_idx  <= bit_idx_n;
            mem_addr <= addr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sr_n      = sr;
        bit_idx_n = bit_idx;
        addr_n    = mem_addr;
        unique case (state)
            S_IDLE: if (en) state_n = fetch_st;
            // A started fetch always completes so mem_rd stays a single-clk strobe.
            S_REQ:  state_n = S_WAIT;
            S_WAIT: begin
                sr_n      = mem_data;
                bit_idx_n = '0;
                cnt_n     = mem_data[0] ? H1 : H0;
                addr_n    = mem_addr + ADDR_W'(1);
                state_n   = S_HI;
            end
            S_HI: if (tick) begin
                if (cnt <= 12'd1) begin
                    cnt_n   = sr[0] ? H1 : H0;
                    state_n = S_LO;
                end else begin
                    cnt_n = cnt - 12'd1;
                end
            end
            S_LO: if (tick) begin
                if (cnt > 12'd1) begin
                    cnt_n = cnt - 12'd1;
                end else if (bit_idx != 3'd7) begin
                    sr_n      = sr >> 1;
                    bit_idx_n = bit_idx + 3'd1;
                    cnt_n     = sr[1] ? H1 : H0;
                    state_n   = S_HI;
                end else begin
                    // Skip IDLE so the inter-byte gap is just REQ + WAIT.
                    cnt_n   = '0;
                    state_n = fetch_st;
                end
            end
            S_EOT:   state_n = S_EOT;
            default: state_n = S_IDLE;
        endcase
        if (rewind) begin
            state_n   = S_IDLE;
            cnt_n     = '0;
            sr_n      = '0;
            bit_idx_n = '0;
            addr_n    = '0;
        end
    end

    assign mem_rd  = (state == S_REQ);
    assign data    = (state == S_HI);
    assign playing = en && (state == S_HI || state == S_LO);
    assign eot     = (state == S_EOT);

endmodule

// File: tb/tb_cas_stream.sv
// Randomised scoreboard bench for cas_stream: expected fetch addresses and waveform
// half-period lengths (in ticks) are queued from the tape contents and popped by a monitor.
module tb_cas_stream;
    localparam int AW = 8;
    localparam int H1 = 2;
    localparam int H0 = 4;

    logic          clk = 1'b0;
    logic          reset, ce, en, rewind;
    logic [AW-1:0] tape_len, mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_data = 8'h00;
    logic          data, playing, eot;

    always #5 clk = ~clk;

    cas_stream #(.ADDR_W(AW), .HALF1(H1), .HALF0(H0)) dut (
        .clk(clk), .reset(reset), .ce(ce), .en(en), .rewind(rewind),
        .tape_len(tape_len), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .data(data), .playing(playing), .eot(eot)
    );

    logic [7:0] tape [0:255];
    always @(posedge clk) if (mem_rd) mem_data <= tape[mem_addr];

    int vecs = 0;
    int errs = 0;

    task automatic check(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        vecs++;
        errs++;
        $display("FAIL %s: got %0d, expected none", name, act);
    endtask

    // ce source: ce_mode N>0 -> every Nth clk, -1 -> random
    int ce_mode = 4;
    int ce_ph = 0;
    initial begin
        ce = 1'b0;
        forever begin
            @(posedge clk); #1;
            ce_ph++;
            ce = (ce_mode < 0) ? ($urandom_range(0, 2) == 0) : ((ce_ph % ce_mode) == 0);
        end
    end

    typedef struct { bit hi; int len; } seg_t;
    int   rd_q[$];
    seg_t seg_q[$];

    task automatic push_tape(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            seg_t s;
            b = tape[i];
            rd_q.push_back(i);
            for (int k = 0; k < 8; k++) begin
                s.len = b[k] ? H1 : H0;
                s.hi = 1'b1; seg_q.push_back(s);
                s.hi = 1'b0; seg_q.push_back(s);
            end
        end
    endtask

    task automatic flush();
        rd_q.delete();
        seg_q.delete();
    endtask

    // Monitor: phase 0 none, 1 high, 2 low; ticks counted per phase.
    int cur = 0, cnt = 0, gap_cnt = 0;
    bit gap_on = 0, gap_dirty = 0, prev_en = 1, prev_data = 0;
    always @(negedge clk) begin
        int nw;
        seg_t s;
        if (reset || rewind) begin
            cur = 0; cnt = 0; gap_on = 0;
        end else begin
            if (mem_rd) begin
                if (rd_q.size() == 0) fail_now("mem_rd_extra", int'(mem_addr));
                else check("rd_addr", int'(mem_addr), rd_q.pop_front());
            end
            if (!en) begin
                if (gap_on) gap_dirty = 1;
                if (prev_data && !data && !prev_en) fail_now("pause_hold", int'(data));
            end else begin
                nw = data ? 1 : (playing ? 2 : 0);
                if (nw != cur) begin
                    if (cur != 0) begin
                        if (seg_q.size() == 0) fail_now("seg_extra", cnt);
                        else begin
                            s = seg_q.pop_front();
                            check(cur == 1 ? "hi_ticks" : "lo_ticks", cnt, s.len);
                            check("seg_level", cur, s.hi ? 1 : 2);
                        end
                    end
                    if (cur == 2 && nw == 0) begin
                        gap_on = 1; gap_cnt = 0; gap_dirty = !prev_en;
                    end
                    if (cur == 0 && nw == 1 && gap_on) begin
                        if (!gap_dirty) check("gap_clk", gap_cnt, 2);
                        gap_on = 0;
                    end
                    cur = nw; cnt = 0;
                end
                if (nw == 0 && gap_on) gap_cnt++;
                if (ce && nw != 0) cnt++;
            end
        end
        prev_en = en;
        prev_data = data;
    end

    task automatic play(input int n);
        en = 1'b0;
        @(posedge clk); #2;
        rewind = 1'b1; tape_len = AW'(n); flush();
        @(posedge clk); #2;
        rewind = 1'b0; push_tape(n); en = 1'b1;
    endtask

    task automatic wait_eot(input string name, input int budget, input int n);
        int t = 0;
        while (!eot && t < budget) begin @(posedge clk); #2; t++; end
        if (!eot) fail_now({name, "_eot_timeout"}, t);
        else begin
            en = 1'b1;
            repeat (2) @(posedge clk); #2;
            check({name, "_eot_addr"}, int'(mem_addr), n);
            check({name, "_eot_data"}, int'(data), 0);
            check({name, "_rd_left"}, rd_q.size(), 0);
            check({name, "_seg_left"}, seg_q.size(), 0);
        end
    endtask

    task automatic wait_cond_data(input int budget);
        int t = 0;
        while (!data && t < budget) begin @(posedge clk); #2; t++; end
        if (!data) fail_now("data_timeout", t);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, d, n;
        reset = 1'b1; en = 1'b0; rewind = 1'b0; tape_len = '0;
        for (int i = 0; i < 256; i++) tape[i] = 8'h00;
        repeat (4) @(posedge clk); #2;
        check("rst_mem_rd", int'(mem_rd), 0);
        check("rst_data", int'(data), 0);
        check("rst_playing", int'(playing), 0);
        check("rst_eot", int'(eot), 0);
        check("rst_addr", int'(mem_addr), 0);
        reset = 1'b0;
        repeat (3) @(posedge clk); #2;

        // single byte A5
        tape[0] = 8'hA5;
        play(1);
        wait_eot("a5", 2000, 1);

        // empty tape
        play(0);
        wait_eot("len0", 2, 0);
        check("len0_eot", int'(eot), 1);

        // three bytes, ce every clk, tight gaps
        ce_mode = 1;
        tape[0] = 8'h00; tape[1] = 8'h01; tape[2] = 8'h80;
        play(3);
        wait_eot("three", 1000, 3);

        // pause in the middle of 0xFF
        ce_mode = 4;
        tape[0] = 8'hFF;
        play(1);
        wait_cond_data(200);
        t = 0;
        while (t < 3) begin @(posedge clk); #2; if (ce) t++; end
        en = 1'b0;
        d = int'(data);
        repeat (50) @(posedge clk); #2;
        check("pause_data", int'(data), d);
        check("pause_playing", int'(playing), 0);
        check("pause_addr", int'(mem_addr), 1);
        en = 1'b1;
        wait_eot("pause", 2000, 1);

        // rewind coincident with a tick while byte 5 plays
        for (int i = 0; i < 7; i++) tape[i] = 8'($urandom);
        play(7);
        t = 0;
        while (!(mem_addr == AW'(6) && data && ce) && t < 3000) begin @(posedge clk); #2; t++; end
        if (t >= 3000) fail_now("rewind_wait_timeout", t);
        rewind = 1'b1; flush(); push_tape(7);
        @(posedge clk); #2;
        rewind = 1'b0;
        check("rew_addr", int'(mem_addr), 0);
        check("rew_data", int'(data), 0);
        check("rew_eot", int'(eot), 0);
        wait_eot("rew", 5000, 7);

        // reset during the low half of bit 3
        for (int i = 0; i < 4; i++) tape[i] = 8'($urandom);
        play(4);
        wait_cond_data(200);
        t = 0; d = 0;
        while (t < 4 && d < 2000) begin
            @(posedge clk); #2; d++;
            if (prev_data && !data) t++;
        end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("arst_data", int'(data), 0);
        check("arst_mem_rd", int'(mem_rd), 0);
        check("arst_addr", int'(mem_addr), 0);
        check("arst_eot", int'(eot), 0);
        flush(); push_tape(4);
        repeat (3) @(posedge clk); #2;
        reset = 1'b0;
        wait_eot("arst", 5000, 4);

        // random tapes, random ce, random pauses
        for (int r = 0; r < 4; r++) begin
            ce_mode = -1;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) tape[i] = 8'($urandom);
            play(n);
            t = 0;
            while (!eot && t < 3000) begin
                @(posedge clk); #2; t++;
                if ($urandom_range(0, 15) == 0) en = !en;
            end
            en = 1'b1;
            wait_eot("rand", 5000, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
